pipe_stage_reg: RTL

Parametrised, handshaked pipeline-stage register for the five-stage MIPS core, the generic replacement for the fixed per-boundary latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data payload and a separate control bundle between stages using valid/ready flow control. It supports flush (bubble insertion) and an optional skid entry for a registered `in_ready`. A saturating stall counter supports performance debug.

---
 rtl/pipe_stage_reg.sv | 94 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and a saturating stall counter; PIPE_STAGE_SKID_EN adds a skid entry and a registered in_ready
module pipe_stage_reg #(
  parameter int DATA_W      = 128,
  parameter int CTRL_W      = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  input  logic                   stall_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
`else
  typedef enum logic {EMPTY, FULL} state_t;
  assign in_ready = out_ready | ~out_valid;
`endif
  state_t state;
  logic in_fire, out_fire;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_data <= '0;
      skid_ctrl <= '0;
      in_ready  <= 1'b1;
`endif
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_ctrl  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl <= '0;
      in_ready  <= 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          state     <= FULL;
          out_valid <= 1'b1;
          out_data  <= in_data;
          out_ctrl  <= in_ctrl;
        end
        FULL: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (in_fire) begin
            state     <= SKID;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            in_ready  <= 1'b0;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: if (out_fire) begin
          state    <= FULL;
          out_data <= skid_data;
          out_ctrl <= skid_ctrl;
          in_ready <= 1'b1;
        end
        default: state <= EMPTY;
`endif
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst || stall_clr) stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
